// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter family: end-of-range modes and
// the ONESHOT run/done state.
package counter_pkg;

  localparam int CNT_WRAP    = 0;
  localparam int CNT_SAT     = 1;
  localparam int CNT_ONESHOT = 2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

endpackage : counter_pkg

// File: rtl/nbit_updown_counter.sv
// General-purpose N-bit up/down counter with runtime terminal value, clear,
// load and wrap / saturate / one-shot end-of-range behaviour.
module nbit_updown_counter
  import counter_pkg::*;
#(
  parameter int N    = 4,
  parameter int MODE = CNT_WRAP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] max_val,
  output logic [N-1:0] count,
  output logic         ovf,
  output logic         done
);

  if (MODE != CNT_WRAP && MODE != CNT_SAT && MODE != CNT_ONESHOT) begin : g_bad_mode
    $error("nbit_updown_counter: MODE must be 0, 1 or 2");
  end
  if (N < 2 || N > 32) begin : g_bad_width
    $error("nbit_updown_counter: N must be in 2..32");
  end

  function automatic logic [N-1:0] clamp_to_max(input logic [N-1:0] v,
                                                input logic [N-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  logic [0:0]   st_q;
  logic [0:0]   st_d;
  logic [N-1:0] cnt_d;
  logic         ovf_d;
  logic         step_ok;
  logic         terminal;

  // In the DONE state of a one-shot the enable is masked entirely.
  assign step_ok  = en && !(MODE == CNT_ONESHOT && st_q == ST_DONE);
  assign terminal = up ? (count >= max_val) : (count == '0);

  always_comb begin
    cnt_d = count;
    ovf_d = 1'b0;
    st_d  = st_q;
    if (clr) begin
      cnt_d = '0;
      st_d  = ST_RUN;
    end else if (load) begin
      cnt_d = clamp_to_max(load_val, max_val);
      st_d  = ST_RUN;
    end else if (step_ok) begin
      if (!terminal) begin
        cnt_d = up ? count + 1'b1 : count - 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (MODE == CNT_WRAP) begin
          cnt_d = up ? '0 : max_val;
        end else if (MODE == CNT_ONESHOT) begin
          st_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
      st_q  <= ST_RUN;
    end else begin
      count <= cnt_d;
      ovf   <= ovf_d;
      st_q  <= st_d;
    end
  end

  assign done = (MODE == CNT_ONESHOT) && (st_q == ST_DONE);

endmodule : nbit_updown_counter

// File: tb/tb_nbit_updown_counter.sv
// Scoreboard bench: one instance per end-of-range mode on shared inputs;
// directed steps queue hand-computed results that a negedge monitor checks.
module tb_nbit_updown_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0, max_val = '0;
  logic [3:0] cnt_w, cnt_s, cnt_o;
  logic       ovf_w, ovf_s, ovf_o, done_w, done_s, done_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    int         dut;
    logic [3:0] cnt;
    logic       ovf;
    logic       done;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  nbit_updown_counter #(.N(4), .MODE(CNT_WRAP)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val), .count(cnt_w), .ovf(ovf_w), .done(done_w));
  nbit_updown_counter #(.N(4), .MODE(CNT_SAT)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val), .count(cnt_s), .ovf(ovf_s), .done(done_s));
  nbit_updown_counter #(.N(4), .MODE(CNT_ONESHOT)) u_one (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .max_val(max_val), .count(cnt_o), .ovf(ovf_o), .done(done_o));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input int d, input logic [3:0] ec, input logic eo,
                         input logic ed, input string nm);
    logic [3:0] ac;
    logic       ao, ad;
    case (d)
      0:       begin ac = cnt_w; ao = ovf_w; ad = done_w; end
      1:       begin ac = cnt_s; ao = ovf_s; ad = done_s; end
      default: begin ac = cnt_o; ao = ovf_o; ad = done_o; end
    endcase
    checks++;
    if (ac !== ec || ao !== eo || ad !== ed) begin
      errors++;
      $display("FAIL %s: got count=%0d ovf=%0b done=%0b, want count=%0d ovf=%0b done=%0b",
               nm, ac, ao, ad, ec, eo, ed);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      compare(mon_e.dut, mon_e.cnt, mon_e.ovf, mon_e.done, mon_e.name);
    end
  end

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [3:0] lv, input logic [3:0] mv, input int d,
                       input logic [3:0] ec, input logic eo, input logic ed,
                       input string nm);
    exp_t x;
    en = e; up = u; clr = c; load = l; load_val = lv; max_val = mv;
    x.cyc = cyc + 1; x.dut = d; x.cnt = ec; x.ovf = eo; x.done = ed; x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] wrap_seq [12];
    wrap_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

    #3;
    compare(0, 4'd0, 1'b0, 1'b0, "reset_wrap");
    compare(1, 4'd0, 1'b0, 1'b0, "reset_sat");
    compare(2, 4'd0, 1'b0, 1'b0, "reset_oneshot");
    #9 rst = 1'b1;

    // WRAP, max 9, counting up from reset
    for (int i = 0; i < 12; i++)
      drive(1, 1, 0, 0, 4'd0, 4'd9, 0, wrap_seq[i], wrap_seq[i] == 4'd0, 0, "wrap_up");

    drive(0, 1, 1, 0, 4'd0, 4'd9, 1, 4'd0, 0, 0, "clr_sat");

    // SATURATE: load 3, count down into the floor
    drive(0, 0, 0, 1, 4'd3, 4'd15, 1, 4'd3, 0, 0, "sat_load");
    drive(1, 0, 0, 0, 4'd3, 4'd15, 1, 4'd2, 0, 0, "sat_down");
    drive(1, 0, 0, 0, 4'd3, 4'd15, 1, 4'd1, 0, 0, "sat_down");
    drive(1, 0, 0, 0, 4'd3, 4'd15, 1, 4'd0, 0, 0, "sat_down");
    drive(0, 0, 0, 0, 4'd3, 4'd15, 1, 4'd0, 0, 0, "sat_idle_hold");
    drive(1, 0, 0, 0, 4'd3, 4'd15, 1, 4'd0, 1, 0, "sat_floor");
    drive(1, 1, 0, 0, 4'd3, 4'd15, 1, 4'd1, 0, 0, "sat_up_after");

    // ONESHOT: max 5, run past the end
    drive(0, 1, 1, 0, 4'd0, 4'd5, 2, 4'd0, 0, 0, "clr_one");
    for (int i = 1; i <= 5; i++)
      drive(1, 1, 0, 0, 4'd0, 4'd5, 2, 4'(i), 0, 0, "one_up");
    drive(1, 1, 0, 0, 4'd0, 4'd5, 2, 4'd5, 1, 1, "one_terminal");
    drive(1, 1, 0, 0, 4'd0, 4'd5, 2, 4'd5, 0, 1, "one_done_hold");
    drive(1, 0, 0, 0, 4'd0, 4'd5, 2, 4'd5, 0, 1, "one_done_down");
    drive(0, 1, 0, 1, 4'd2, 4'd5, 2, 4'd2, 0, 0, "one_reload");
    drive(1, 1, 0, 0, 4'd2, 4'd5, 2, 4'd3, 0, 0, "one_rerun");

    // Priority clr > load > en, and load clamped to max_val
    drive(0, 1, 0, 1, 4'd7, 4'd9, 0, 4'd7, 0, 0, "prio_load7");
    drive(1, 1, 1, 1, 4'd3, 4'd9, 0, 4'd0, 0, 0, "prio_clr_wins");
    drive(1, 1, 0, 1, 4'd12, 4'd9, 0, 4'd9, 0, 0, "load_clamp");
    drive(1, 0, 0, 1, 4'd4, 4'd9, 0, 4'd4, 0, 0, "load_beats_en");

    // WRAP with max_val lowered under the count
    drive(0, 1, 0, 1, 4'd8, 4'd9, 0, 4'd8, 0, 0, "wrap_load8");
    drive(1, 1, 0, 0, 4'd0, 4'd4, 0, 4'd0, 1, 0, "wrap_lowered_max");
    drive(1, 0, 0, 0, 4'd0, 4'd4, 0, 4'd4, 1, 0, "wrap_down_term");
    drive(1, 0, 0, 0, 4'd0, 4'd4, 0, 4'd3, 0, 0, "wrap_down");

    // WRAP with max_val 0: ovf every enabled cycle
    drive(0, 1, 1, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0, "clr_max0");
    drive(1, 1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 1, 0, "max0_ovf");
    drive(1, 1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 1, 0, "max0_ovf");

    // Asynchronous reset mid-count
    drive(0, 1, 1, 0, 4'd0, 4'd9, 0, 4'd0, 0, 0, "clr_rst");
    for (int i = 1; i <= 6; i++)
      drive(1, 1, 0, 0, 4'd0, 4'd9, 0, 4'(i), 0, 0, "pre_rst_up");
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    compare(0, 4'd0, 1'b0, 1'b0, "async_rst_wrap");
    compare(2, 4'd0, 1'b0, 1'b0, "async_rst_one");
    #1 rst = 1'b1;
    drive(1, 1, 0, 0, 4'd0, 4'd9, 0, 4'd1, 0, 0, "post_rst_up");
    drive(1, 1, 0, 0, 4'd0, 4'd9, 0, 4'd2, 0, 0, "post_rst_up");

    en = 1'b0;
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_nbit_updown_counter
